// File: rtl/raw10_byte2pixel.sv
// CSI-2 RAW10 payload unpacker: 5 payload bytes become 4 ten-bit pixels, one per clock,
// with frame_valid/line_valid regenerated from FS/FE/long-packet-start events.
module raw10_byte2pixel #(
    parameter int unsigned PD_BUS_WIDTH = 10,
    parameter int unsigned WC_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fs_i,
    input  logic                    fe_i,
    input  logic                    lp_start_i,
    input  logic [WC_WIDTH-1:0]     wc_i,
    input  logic [7:0]              byte_i,
    input  logic                    byte_en_i,
    output logic [PD_BUS_WIDTH-1:0] pixel_data,
    output logic                    de_o,
    output logic                    line_valid,
    output logic                    frame_valid,
    output logic                    wc_err_o
);

    localparam int unsigned AW = WC_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                          state_q, state_n;
    logic [WC_WIDTH-1:0]             rem_q, rem_n;
    logic [2:0]                      grp_q, grp_n;
    logic [3:0][7:0]                 hi_q, hi_n;
    logic [2:0][PD_BUS_WIDTH-1:0]    obuf_q, obuf_n;
    logic [1:0]                      cnt_q, cnt_n;
    logic                            fe_pend_q, fe_pend_n;
    logic [PD_BUS_WIDTH-1:0]         pix_n;
    logic                            de_n, lv_n, fv_n, err_n;
    logic                            accept, lv_kill;
    logic [AW-1:0]                   avail;

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            grp_q       <= '0;
            hi_q        <= '0;
            obuf_q      <= '0;
            cnt_q       <= '0;
            fe_pend_q   <= 1'b0;
            pixel_data  <= '0;
            de_o        <= 1'b0;
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
            wc_err_o    <= 1'b0;
        end else begin
            state_q     <= state_n;
            rem_q       <= rem_n;
            grp_q       <= grp_n;
            hi_q        <= hi_n;
            obuf_q      <= obuf_n;
            cnt_q       <= cnt_n;
            fe_pend_q   <= fe_pend_n;
            pixel_data  <= pix_n;
            de_o        <= de_n;
            line_valid  <= lv_n;
            frame_valid <= fv_n;
            wc_err_o    <= err_n;
        end
    end

    // Next-state: drain, byte unpacking, then frame/line events (fs > fe > lp_start)
    always_comb begin
        state_n   = state_q;
        rem_n     = rem_q;
        grp_n     = grp_q;
        hi_n      = hi_q;
        obuf_n    = obuf_q;
        cnt_n     = cnt_q;
        fe_pend_n = fe_pend_q;
        pix_n     = pixel_data;
        de_n      = 1'b0;
        fv_n      = frame_valid;
        err_n     = wc_err_o;
        lv_kill   = 1'b0;
        lv_n      = 1'b0;
        avail     = '0;

        if (cnt_q != 2'd0) begin
            pix_n     = obuf_q[0];
            obuf_n[0] = obuf_q[1];
            obuf_n[1] = obuf_q[2];
            obuf_n[2] = '0;
            cnt_n     = cnt_q - 2'd1;
            de_n      = 1'b1;
        end

        if (state_q == S_DRAIN && cnt_n == 2'd0) begin
            state_n = S_IDLE;
        end

        accept = byte_en_i && (state_q == S_RECV) && (rem_q != '0)
                 && !fs_i && !fe_i && !lp_start_i;

        if (accept) begin
            rem_n = rem_q - WC_WIDTH'(1);
            if (grp_q == 3'd4) begin
                // Last byte of the group carries the two LSBs of all four pixels
                grp_n     = 3'd0;
                pix_n     = PD_BUS_WIDTH'({hi_q[0], byte_i[1:0]});
                obuf_n[0] = PD_BUS_WIDTH'({hi_q[1], byte_i[3:2]});
                obuf_n[1] = PD_BUS_WIDTH'({hi_q[2], byte_i[5:4]});
                obuf_n[2] = PD_BUS_WIDTH'({hi_q[3], byte_i[7:6]});
                cnt_n     = 2'd3;
                de_n      = 1'b1;
            end else begin
                hi_n[grp_q[1:0]] = byte_i;
                grp_n            = grp_q + 3'd1;
            end
            if (rem_n == '0) begin
                state_n = S_DRAIN;
                if (grp_n != 3'd0) begin
                    err_n = 1'b1;
                end
            end
        end

        if (fs_i) begin
            fv_n      = 1'b1;
            fe_pend_n = 1'b0;
            state_n   = S_IDLE;
            rem_n     = '0;
            grp_n     = '0;
            cnt_n     = '0;
            de_n      = 1'b0;
            lv_kill   = 1'b1;
            if (frame_valid) begin
                err_n = 1'b1;
            end else if (state_q == S_IDLE) begin
                err_n = 1'b0;
            end
        end else if (fe_i && frame_valid) begin
            if (state_q == S_IDLE && !line_valid) begin
                fv_n = 1'b0;
            end else begin
                // Let the in-flight buffer finish; a partial group is abandoned
                fe_pend_n = 1'b1;
                if (state_q == S_RECV) begin
                    state_n = S_DRAIN;
                    rem_n   = '0;
                    grp_n   = '0;
                end
            end
        end else if (lp_start_i) begin
            if (!frame_valid) begin
                err_n = 1'b1;
            end else begin
                if (state_q != S_IDLE) begin
                    err_n = 1'b1;
                end
                cnt_n   = '0;
                de_n    = 1'b0;
                lv_kill = 1'b1;
                rem_n   = wc_i;
                grp_n   = '0;
                state_n = (wc_i == '0) ? S_IDLE : S_RECV;
            end
        end else if (fe_pend_q && state_q == S_IDLE && !line_valid) begin
            fv_n      = 1'b0;
            fe_pend_n = 1'b0;
        end

        // line_valid bridges gaps only while the remaining bytes can still finish a group
        avail = {1'b0, rem_n} + AW'(grp_n);
        if (!lv_kill) begin
            lv_n = de_n || (line_valid && ((cnt_n != 2'd0) ||
                   (state_n == S_RECV && avail >= AW'(5))));
        end
    end

endmodule

// File: doc/raw10_byte2pixel.md
Name: raw10_byte2pixel

Overview:
- Unpacks CSI-2 RAW10 long-packet payload bytes into 10-bit pixels, one pixel per clock.
- Regenerates frame_valid/line_valid timing from frame-start, frame-end and line-start events.
- Sits between the CSI-2 packet parser and the pixel sink; its output bus feeds the pixel monitor directly (CSI2 mode, PIXEL_COUNT=1, TX_CH=1).

Parameters:
- PD_BUS_WIDTH, 10, pixel width; only 10 is supported (RAW10).
- WC_WIDTH, 16, width of the long-packet word count.

Ports:
- clk  in  1  pixel/byte clock
- reset  in  1  asynchronous, active-high reset
- fs_i  in  1  one-cycle pulse, frame-start short packet
- fe_i  in  1  one-cycle pulse, frame-end short packet
- lp_start_i  in  1  one-cycle pulse, long-packet header accepted; wc_i valid this cycle
- wc_i  in  WC_WIDTH  payload byte count
- byte_i  in  8  payload byte
- byte_en_i  in  1  byte_i valid
- pixel_data  out  PD_BUS_WIDTH  unpacked pixel
- de_o  out  1  pixel_data valid
- line_valid  out  1  line active
- frame_valid  out  1  frame active
- wc_err_o  out  1  sticky error flag

Behaviour:
- Reset is asynchronous and active-high. On assertion, all outputs, counters and buffers clear to 0 immediately, regardless of operation in progress. A partially received line is discarded; the next line is accepted only after a new lp_start_i.
- RAW10 group format: 5 bytes B0..B4 form 4 pixels.
  - Pixel k = {Bk, B4[2k+1:2k]} for k = 0..3.
  - Pixel 0 is output first.
- Byte acceptance:
  - Bytes are accepted only when byte_en_i=1, a line is open, and the remaining count is nonzero.
  - Bytes arriving at any other time are ignored.
- Counters:
  - rem (WC_WIDTH bits) is loaded with wc_i on lp_start_i and decrements per accepted byte.
  - grp_idx (0..4) increments per accepted byte, wraps 4->0, and clears on lp_start_i.
- Accepting B4 at cycle t loads a 4x10 output buffer and sets out_cnt=4.
  - Pixels appear on cycles t+1..t+4 with de_o=1, one per cycle.
  - Input gaps never stall a drain in progress.
  - Next group completes no earlier than t+5, so no overflow or backpressure is possible.
- pixel_data holds its last value while de_o=0.
- Line state machine: IDLE -> RECV -> DRAIN -> IDLE.
  - IDLE -> RECV on lp_start_i while frame_valid=1. lp_start_i while frame_valid=0 is ignored and sets wc_err_o.
  - RECV -> DRAIN when rem reaches 0.
  - DRAIN -> IDLE once out_cnt=0.
  - lp_start_i while in RECV/DRAIN: current line truncated, unemitted buffer discarded, new line starts, wc_err_o set.
- line_valid:
  - Rises in the same cycle as the first de_o of the line.
  - Stays high through inter-group gaps (de_o=0 in gaps).
  - Falls the cycle after the last pixel.
  - Zero-length lines (wc_i=0) produce no line_valid and return to IDLE.
- wc_i not a multiple of 5: trailing 1-4 bytes are accepted but dropped; no partial pixels are emitted; wc_err_o is set.
- frame_valid:
  - Rises the cycle after fs_i.
  - fe_i in IDLE: falls the cycle after fe_i.
  - fe_i in RECV/DRAIN: fe is held pending; frame_valid falls the cycle after line_valid falls. A line still in RECV is truncated at fe.
  - fs_i while frame_valid=1: frame restarts, open line truncated, wc_err_o set.
  - fs_i and fe_i in the same cycle: fe is ignored and fs wins.
- wc_err_o is sticky and clears on the next fs_i that arrives with the block in IDLE, or on reset.
- Throughput: sustained 0.8 pixel/clk for continuous byte_en_i.

Test Plan:
- Basic line: fs; lp_start wc=5; bytes 0x12,0x34,0x56,0x78,0xE4 back-to-back -> pixels 0x048,0x0D1,0x15A,0x1E3 on 4 consecutive cycles, line_valid high exactly those 4 cycles. Then fe -> frame_valid low one cycle later.
- Gapped input: wc=10 with byte_en_i=0 between every byte -> 8 pixels in order, line_valid continuous from first to last pixel, de_o low in gaps, no lost or duplicated pixels.
- Bad word count: wc=7 -> 4 pixels emitted, last 2 bytes dropped, wc_err_o=1 until next fs in IDLE.
- Early fe: fe_i asserted during the last group's drain -> frame_valid stays high until the cycle after line_valid falls.
- Reset mid-line: assert reset after byte 3 of a 10-byte line -> outputs 0 immediately. After release, fs + wc=5 -> correct 4 pixels with no stale data.
- Protocol errors: lp_start with frame_valid=0 -> no pixels, wc_err_o=1. Simultaneous fs/fe -> frame_valid=1.
